mitm_mode_sequencer: RTL and testbench

Sequences run-time mode changes for the MITM datapath. Raw mode switches are synchronized, debounced and validated, and a new mode is committed only when the bus is quiescent, so that no frame is half-forwarded and half-substituted. The block sits between the board mode inputs and the MITM logic mode input. It also drives a hold request that makes the MITM logic stop starting new fake transfers while a switch is pending.

---
 rtl/mitm_mode_sequencer.sv | 151 +++++++++++++++
 tb/tb_mitm_mode_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mitm_mode_sequencer.sv
// Mode-change sequencer: synchronizes and debounces the raw mode switches,
// then commits a new one-hot mode only once the bus has been quiet long enough.
module mitm_mode_sequencer #(
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned QUIET_CYCLES    = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [NUM_MODES-1:0] mode_select_raw,
  input  logic                 if0_busy,
  input  logic                 if1_busy,
  input  logic                 mitm_busy,
  output logic [NUM_MODES-1:0] mode,
  output logic                 hold,
  output logic                 switch_done,
  output logic                 switch_timeout,
  output logic                 invalid_sel
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DW-1:0]        DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [QW-1:0]        QUIET_MAX = QW'(QUIET_CYCLES - 1);
  localparam logic [TW-1:0]        TIME_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_MODES-1:0] MODE_FWD = NUM_MODES'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    QUIET  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  function automatic logic is_onehot(input logic [NUM_MODES-1:0] v);
    return (v != '0) && ((v & (v - NUM_MODES'(1))) == '0);
  endfunction

  logic [NUM_MODES-1:0] sync1;
  logic [NUM_MODES-1:0] sync2;
  logic [NUM_MODES-1:0] deb_sel;
  logic [DW-1:0]        deb_cnt;
  logic                 deb_valid;

  state_t               state;
  logic [NUM_MODES-1:0] target;
  logic [QW-1:0]        quiet_cnt;
  logic [TW-1:0]        time_cnt;
  logic                 forced;
  logic                 bus_idle;

  assign deb_valid = is_onehot(deb_sel);
  assign bus_idle  = !if0_busy && !if1_busy && !mitm_busy;

  // Two-flop synchronizer, stability counter and debounced selection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      deb_cnt     <= '0;
      deb_sel     <= MODE_FWD;
      invalid_sel <= 1'b0;
    end else begin
      sync1       <= mode_select_raw;
      sync2       <= sync1;
      invalid_sel <= 1'b0;
      if (sync1 != sync2) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      if (deb_cnt == DEB_MAX) begin
        deb_sel <= sync2;
        if (sync2 != deb_sel && !is_onehot(sync2)) begin
          invalid_sel <= 1'b1;
        end
      end
    end
  end

  // Switch FSM: request, drain MITM transfers, wait for a quiet bus, commit.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mode           <= MODE_FWD;
      target         <= MODE_FWD;
      hold           <= 1'b0;
      switch_done    <= 1'b0;
      switch_timeout <= 1'b0;
      quiet_cnt      <= '0;
      time_cnt       <= '0;
      forced         <= 1'b0;
    end else begin
      switch_done    <= 1'b0;
      switch_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (deb_valid && deb_sel != mode) begin
            target   <= deb_sel;
            hold     <= 1'b1;
            time_cnt <= '0;
            state    <= DRAIN;
          end
        end
        DRAIN, QUIET: begin
          if (deb_sel == mode) begin
            // Request withdrawn: drop hold without committing.
            hold  <= 1'b0;
            state <= IDLE;
          end else begin
            if (deb_valid && deb_sel != target) begin
              target <= deb_sel;
            end
            if (time_cnt != TIME_MAX) begin
              time_cnt <= time_cnt + TW'(1);
            end
            if (time_cnt == TIME_MAX) begin
              forced <= 1'b1;
              state  <= COMMIT;
            end else if (state == DRAIN) begin
              if (!mitm_busy) begin
                quiet_cnt <= '0;
                state     <= QUIET;
              end
            end else if (bus_idle) begin
              if (quiet_cnt == QUIET_MAX) begin
                state <= COMMIT;
              end else begin
                quiet_cnt <= quiet_cnt + QW'(1);
              end
            end else begin
              quiet_cnt <= '0;
            end
          end
        end
        COMMIT: begin
          mode           <= target;
          hold           <= 1'b0;
          switch_done    <= 1'b1;
          switch_timeout <= forced;
          forced         <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mitm_mode_sequencer.sv
// Bench for mitm_mode_sequencer: table of mode requests plus hand-written
// glitch, invalid, abort and reset sequences; commits scored from a queue.
module tb_mitm_mode_sequencer;

  localparam int unsigned NM  = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned QC  = 8;
  localparam int unsigned TO  = 32;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [NM-1:0] raw;
  logic          if0_busy;
  logic          if1_busy;
  logic          mitm_busy;
  logic [NM-1:0] mode;
  logic          hold;
  logic          switch_done;
  logic          switch_timeout;
  logic          invalid_sel;

  mitm_mode_sequencer #(
    .NUM_MODES      (NM),
    .DEBOUNCE_CYCLES(DEB),
    .QUIET_CYCLES   (QC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk        (clk),
    .rst_n          (rst_n),
    .mode_select_raw(raw),
    .if0_busy       (if0_busy),
    .if1_busy       (if1_busy),
    .mitm_busy      (mitm_busy),
    .mode           (mode),
    .hold           (hold),
    .switch_done    (switch_done),
    .switch_timeout (switch_timeout),
    .invalid_sel    (invalid_sel)
  );

  always #5 clk = ~clk;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  int inv_cnt  = 0;
  int rise_cyc = 0;
  logic hold_q = 1'b0;

  typedef struct {
    logic [NM-1:0] exp_mode;
    int            exp_lat;
    bit            exp_to;
  } exp_t;

  typedef struct {
    logic [NM-1:0] raw;
    int            busy_sel;  // 0 none, 1 if0_busy, 2 if1_busy
    int            busy_at;   // clock edge after hold rise that sees the busy pulse
    bit            mitm;      // hold mitm_busy high for the whole request
    logic [NM-1:0] exp_mode;
    int            exp_lat;   // cycles from hold rise to switch_done
    bit            exp_to;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: hold edges, invalid pulses, and scoreboard pop on every commit.
  always @(negedge clk) begin
    if (hold && !hold_q) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (invalid_sel) inv_cnt++;
    if (switch_timeout && !switch_done) check("timeout_without_done", 1, 0);
    if (switch_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_switch_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("commit_mode", int'(mode), int'(e.exp_mode));
        check("commit_timeout_flag", int'(switch_timeout), int'(e.exp_to));
        check("commit_latency", cyc - rise_cyc, e.exp_lat);
        check("hold_low_at_commit", int'(hold), 0);
        check("hold_high_before_commit", int'(hold_q), 1);
      end
    end
    hold_q = hold;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected below 20000", cyc);
    $fatal(1);
  end

  task automatic wait_hold_rise(output int lat, input int c0);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hold) begin
        lat = cyc - c0;
        break;
      end
    end
  endtask

  initial begin
    int c0;
    int lat;
    int r0;
    int d0;
    int i0;

    // Idle bus: hold 10 cycles. Busy edge k restarts the count: k+QC+1.
    // Forced commit: timeout decision at edge 32, commit one edge later.
    vecs[0] = '{raw: 4'b0100, busy_sel: 0, busy_at: 0, mitm: 1'b0, exp_mode: 4'b0100, exp_lat: 10, exp_to: 1'b0};
    vecs[1] = '{raw: 4'b0010, busy_sel: 1, busy_at: 7, mitm: 1'b0, exp_mode: 4'b0010, exp_lat: 16, exp_to: 1'b0};
    vecs[2] = '{raw: 4'b1000, busy_sel: 0, busy_at: 0, mitm: 1'b1, exp_mode: 4'b1000, exp_lat: 33, exp_to: 1'b1};
    vecs[3] = '{raw: 4'b0010, busy_sel: 2, busy_at: 4, mitm: 1'b0, exp_mode: 4'b0010, exp_lat: 13, exp_to: 1'b0};
    vecs[4] = '{raw: 4'b0001, busy_sel: 0, busy_at: 0, mitm: 1'b0, exp_mode: 4'b0001, exp_lat: 10, exp_to: 1'b0};

    raw       = 4'b0001;
    if0_busy  = 1'b0;
    if1_busy  = 1'b0;
    mitm_busy = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    check("reset_mode", int'(mode), 1);
    check("reset_hold", int'(hold), 0);
    check("reset_switch_done", int'(switch_done), 0);
    check("reset_switch_timeout", int'(switch_timeout), 0);
    check("reset_invalid_sel", int'(invalid_sel), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_mode_after_reset", int'(mode), 1);
    check("idle_no_hold_after_reset", rise_cnt, 0);

    // Table-driven mode requests.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      d0 = done_cnt;
      sb.push_back('{exp_mode: vecs[v].exp_mode, exp_lat: vecs[v].exp_lat, exp_to: vecs[v].exp_to});
      raw       = vecs[v].raw;
      mitm_busy = vecs[v].mitm;
      c0        = cyc;
      wait_hold_rise(lat, c0);
      check("hold_rise_latency", lat, 2 + DEB + 1);
      if (vecs[v].busy_at > 0) begin
        repeat (vecs[v].busy_at - 1) @(negedge clk);
        if (vecs[v].busy_sel == 1) if0_busy = 1'b1;
        else                       if1_busy = 1'b1;
        @(negedge clk);
        if0_busy = 1'b0;
        if1_busy = 1'b0;
      end
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (done_cnt != d0) break;
      end
      check("switch_done_count", done_cnt - d0, 1);
      mitm_busy = 1'b0;
      repeat (3) @(negedge clk);
    end

    // Glitch shorter than the debounce window is rejected.
    r0 = rise_cnt;
    d0 = done_cnt;
    @(negedge clk);
    raw = 4'b1000;
    repeat (3) @(negedge clk);
    raw = 4'b0001;
    repeat (15) @(negedge clk);
    check("glitch_no_hold", rise_cnt - r0, 0);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_mode", int'(mode), 1);

    // Non-one-hot selection: one invalid pulse, no request.
    i0  = inv_cnt;
    raw = 4'b0110;
    repeat (12) @(negedge clk);
    check("invalid_pulse_count", inv_cnt - i0, 1);
    check("invalid_no_hold", rise_cnt - r0, 0);
    raw = 4'b0001;
    repeat (12) @(negedge clk);
    check("invalid_pulse_once", inv_cnt - i0, 1);
    check("invalid_mode", int'(mode), 1);

    // Request withdrawn while draining: hold drops, nothing commits.
    d0        = done_cnt;
    mitm_busy = 1'b1;
    raw       = 4'b0010;
    c0        = cyc;
    wait_hold_rise(lat, c0);
    check("abort_hold_rise_latency", lat, 2 + DEB + 1);
    raw = 4'b0001;
    repeat (10) @(negedge clk);
    check("abort_hold_dropped", int'(hold), 0);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_mode", int'(mode), 1);
    mitm_busy = 1'b0;
    repeat (5) @(negedge clk);

    // Reset asserted in QUIET takes effect without a clock edge.
    raw = 4'b0100;
    c0  = cyc;
    wait_hold_rise(lat, c0);
    check("rst_hold_rise_latency", lat, 2 + DEB + 1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    raw = 4'b0001;
    #1;
    check("async_rst_hold", int'(hold), 0);
    check("async_rst_mode", int'(mode), 1);
    check("async_rst_done", int'(switch_done), 0);
    check("async_rst_timeout", int'(switch_timeout), 0);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_mode", int'(mode), 1);
    check("post_rst_no_done", done_cnt - d0, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
